pacman_game_core: RTL and testbench
===================================

Name: pacman_game_core

Overview:
- Parametrised game engine for the Lab5 Pac-Man design. Generalises single-ghost, single-fruit play to NUM_GHOSTS ghosts, NUM_FRUITS fruits, a configurable grid and a lives counter.
- Owns the game state machine, Pac-Man and ghost position registers, fruit bitmap, score, step count and collision logic.
- Sits between the debounced button/tick sources and the VGA, seven-segment and LED display blocks.

Parameters:
- GRID_W, 8, grid columns (>=2)
- GRID_H, 8, grid rows (>=2)
- NUM_GHOSTS, 2, ghost count (1..GRID_H)
- NUM_FRUITS, 3, fruit count (1..GRID_H)
- LIVES, 3, lives at game start (1..7)
- FRUIT_POINTS, 100, score added per fruit eaten
- HIT_TICKS, 4, number of g_tick pulses spent in HIT

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins or restarts a game
- up, down, left, right  in  1 each  debounced one-cycle move pulses
- g_tick  in  1  one-cycle ghost/timer pulse
- pac_x  out  XW  Pac-Man column; XW = $clog2(GRID_W)
- pac_y  out  YW  Pac-Man row; YW = $clog2(GRID_H)
- ghost_x  out  NUM_GHOSTS*XW  packed ghost columns; ghost 0 in the LSBs
- ghost_y  out  NUM_GHOSTS*YW  packed ghost rows; ghost 0 in the LSBs
- fruit_alive  out  NUM_FRUITS  bit j = 1 while fruit j is uneaten
- score  out  14  score, saturating at 9999
- steps  out  14  accepted moves, saturating at 9999
- lives  out  3  remaining lives
- state  out  3  game state: IDLE=0, PLAY=1, HIT=2, WIN=3, LOSE=4

Behaviour:
- Spawn positions:
  - Pac-Man at (0,0).
  - Ghost i at (GRID_W-1-(i mod GRID_W), GRID_H-1-i).
  - Fruit j at (GRID_W-1, j); fixed for the whole game.
- Reset (synchronous, highest priority) and "init" both set:
  - state=IDLE, all entities at spawn, fruit_alive=all ones, score=0, steps=0, lives=LIVES, every ghost direction = +x.
- IDLE:
  - start -> init, then PLAY.
  - Move pulses and g_tick are ignored.
- PLAY, moves:
  - When several move pulses arrive in the same cycle, only one is honoured: up > down > left > right.
  - up means y-1, down y+1, left x-1, right x+1.
  - A move into the grid edge is blocked: the position holds and steps does not increment.
  - An accepted move updates pac_x/pac_y at the next edge and increments steps.
- PLAY, ghosts (on g_tick):
  - Every ghost moves one column in its direction.
  - At column 0 or GRID_W-1 the ghost reverses direction and moves that same tick. It never leaves the grid.
- Detection:
  - Collision and fruit detection are combinational on the registered positions. Their effect is registered at the next edge, one cycle after the positions change.
- Fruit:
  - Pac-Man on an alive fruit -> clear its bit and add FRUIT_POINTS to score (saturating at 9999).
  - The last fruit cleared -> WIN.
- Ghost collision:
  - Pac-Man equal to any ghost -> lives decrements.
  - If lives was 1, go to LOSE (lives=0); otherwise go to HIT.
- Simultaneous last fruit and ghost collision in the same cycle: WIN, and lives is unchanged.
- A move pulse and g_tick in the same cycle: both are applied. Collision is evaluated on the resulting positions.
- HIT:
  - Entities are frozen; move pulses are ignored.
  - The HIT counter counts g_tick pulses. At the HIT_TICKS-th pulse, Pac-Man and ghosts respawn (fruits and score are kept) and state returns to PLAY.
- WIN/LOSE:
  - Terminal: all outputs hold.
  - start -> init, then PLAY directly.
- start during PLAY or HIT -> init, then PLAY. start has priority over every in-cycle event except reset.

Optional Feature:
- GHOST_CHASE_EN defined:
  - On g_tick, each odd-indexed ghost moves one step toward Pac-Man instead of patrolling.
  - It reduces |dx| first, and |dy| only when dx=0.
  - Even-indexed ghosts still patrol.
- GHOST_CHASE_EN undefined: all ghosts patrol.

Decomposition:
- Package pacman_pkg holds:
  - the state encoding constants IDLE..LOSE;
  - the score/steps width (14) and saturation value 9999;
  - the function coord_w(n) = $clog2(n).
- Sub-module ghost_unit, generated once per ghost:
  - holds the position and direction registers, spawn values and the patrol/chase step;
  - inputs: tick enable, respawn, and Pac-Man position (chase mode).

Test Plan:
- reset, start, then right x7 -> pac=(7,0), fruit_alive=3'b110, score=100, steps=7; an 8th right -> steps stays 7.
- up and left pulsed in the same cycle from (3,3) -> pac=(3,2), steps +1; down at y=7 -> blocked, steps unchanged.
- Default params, g_tick x8 from spawn -> ghost0 x: 7,6,...,0, then 1 (reversed, +x); verify ghost1 sequence likewise.
- Drive Pac-Man into a ghost with lives=3 -> next cycle state=HIT, lives=2; 4 g_ticks -> PLAY with Pac-Man at (0,0) and fruit_alive preserved.
- Three collisions -> LOSE with lives=0; outputs hold; start -> PLAY with lives=3, score=0.
- Last fruit and ghost on the same cell in the same cycle -> WIN, lives unchanged; repeat with GHOST_CHASE_EN and check ghost1 closes on Pac-Man one step per tick.

Source files
------------

// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - shared state encoding, score width/saturation and coordinate width helper
package pacman_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    HIT  = 3'd2,
    WIN  = 3'd3,
    LOSE = 3'd4
  } game_state_t;

  localparam int SCORE_W = 14;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

  function automatic int coord_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pacman_game_core_if.sv
// rtl/pacman_game_core_if.sv - button/tick inputs and display-facing game state of the Pac-Man core
interface pacman_game_core_if #(
  parameter int GRID_W     = 8,
  parameter int GRID_H     = 8,
  parameter int NUM_GHOSTS = 2,
  parameter int NUM_FRUITS = 3
);
  localparam int XW = pacman_pkg::coord_w(GRID_W);
  localparam int YW = pacman_pkg::coord_w(GRID_H);

  logic                     start;
  logic                     up;
  logic                     down;
  logic                     left;
  logic                     right;
  logic                     g_tick;
  logic [XW-1:0]            pac_x;
  logic [YW-1:0]            pac_y;
  logic [NUM_GHOSTS*XW-1:0] ghost_x;
  logic [NUM_GHOSTS*YW-1:0] ghost_y;
  logic [NUM_FRUITS-1:0]    fruit_alive;
  logic [13:0]              score;
  logic [13:0]              steps;
  logic [2:0]               lives;
  logic [2:0]               state;

  modport master (
    output start, up, down, left, right, g_tick,
    input  pac_x, pac_y, ghost_x, ghost_y, fruit_alive, score, steps, lives, state
  );

  modport slave (
    input  start, up, down, left, right, g_tick,
    output pac_x, pac_y, ghost_x, ghost_y, fruit_alive, score, steps, lives, state
  );

endinterface

// File: rtl/ghost_unit.sv
// rtl/ghost_unit.sv - one ghost: position/direction registers, spawn point and per-tick step
// GHOST_CHASE_EN: odd-indexed ghosts step toward Pac-Man instead of patrolling their row.
module ghost_unit
  import pacman_pkg::*;
#(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter int IDX    = 0
) (
  input  logic                           clk,
  input  logic                           respawn,
  input  logic                           tick,
  input  logic [coord_w(GRID_W)-1:0]     pac_x,
  input  logic [coord_w(GRID_H)-1:0]     pac_y,
  output logic [coord_w(GRID_W)-1:0]     x,
  output logic [coord_w(GRID_H)-1:0]     y
);
  localparam int XW = coord_w(GRID_W);
  localparam int YW = coord_w(GRID_H);
  localparam logic [XW-1:0] SPAWN_X = XW'(GRID_W - 1 - (IDX % GRID_W));
  localparam logic [YW-1:0] SPAWN_Y = YW'(GRID_H - 1 - IDX);
  localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);

`ifdef GHOST_CHASE_EN
  localparam bit CHASE = (IDX % 2) == 1;
`else
  localparam bit CHASE = 1'b0;
  logic unused_pac;
  assign unused_pac = ^{pac_x, pac_y};
`endif

  logic dir_neg;

  // A patrolling ghost at a wall turns around and still moves on that tick.
  always_ff @(posedge clk) begin
    if (respawn) begin
      x       <= SPAWN_X;
      y       <= SPAWN_Y;
      dir_neg <= 1'b0;
    end else if (tick) begin
      if (CHASE) begin
        if (pac_x > x)      x <= x + 1'b1;
        else if (pac_x < x) x <= x - 1'b1;
        else if (pac_y > y) y <= y + 1'b1;
        else if (pac_y < y) y <= y - 1'b1;
      end else if (!dir_neg) begin
        if (x == X_MAX) begin
          dir_neg <= 1'b1;
          x       <= x - 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end else begin
        if (x == '0) begin
          dir_neg <= 1'b0;
          x       <= x + 1'b1;
        end else begin
          x <= x - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pacman_game_core.sv
// rtl/pacman_game_core.sv - Pac-Man game engine: state machine, Pac-Man moves, fruit and ghost collision
// Optional build macro GHOST_CHASE_EN (used in ghost_unit) turns odd-indexed ghosts into chasers.
module pacman_game_core
  import pacman_pkg::*;
#(
  parameter int GRID_W       = 8,
  parameter int GRID_H       = 8,
  parameter int NUM_GHOSTS   = 2,
  parameter int NUM_FRUITS   = 3,
  parameter int LIVES        = 3,
  parameter int FRUIT_POINTS = 100,
  parameter int HIT_TICKS    = 4
) (
  input logic               clk,
  input logic               reset,
  pacman_game_core_if.slave bus
);
  localparam int XW  = coord_w(GRID_W);
  localparam int YW  = coord_w(GRID_H);
  localparam int HCW = $clog2(HIT_TICKS + 1);
  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

  game_state_t              state;
  logic [XW-1:0]            pac_x, next_x;
  logic [YW-1:0]            pac_y, next_y;
  logic [NUM_GHOSTS*XW-1:0] ghost_x;
  logic [NUM_GHOSTS*YW-1:0] ghost_y;
  logic [NUM_GHOSTS-1:0]    ghost_hit;
  logic [NUM_FRUITS-1:0]    fruit_alive, fruit_hit;
  logic [SCORE_W-1:0]       score, steps;
  logic [2:0]               lives;
  logic [HCW-1:0]           hit_cnt;
  logic move_ok, go_win, go_hit, hit_done, ghost_tick, respawn;

  always_comb begin
    fruit_hit = '0;
    for (int j = 0; j < NUM_FRUITS; j++)
      fruit_hit[j] = fruit_alive[j] && (pac_x == X_MAX) && (pac_y == YW'(j));
  end

  // Only the highest-priority pulse counts, even when that one is blocked by the edge.
  always_comb begin
    move_ok = 1'b0;
    next_x  = pac_x;
    next_y  = pac_y;
    if (bus.up) begin
      move_ok = (pac_y != '0);
      next_y  = pac_y - 1'b1;
    end else if (bus.down) begin
      move_ok = (pac_y != Y_MAX);
      next_y  = pac_y + 1'b1;
    end else if (bus.left) begin
      move_ok = (pac_x != '0);
      next_x  = pac_x - 1'b1;
    end else if (bus.right) begin
      move_ok = (pac_x != X_MAX);
      next_x  = pac_x + 1'b1;
    end
  end

  assign go_win     = (|fruit_hit) && ((fruit_alive & ~fruit_hit) == '0);
  assign go_hit     = (|ghost_hit) && !go_win;
  assign ghost_tick = (state == PLAY) && !bus.start && !go_win && !go_hit && bus.g_tick;
  assign hit_done   = (state == HIT) && !bus.start && bus.g_tick && (hit_cnt == HCW'(HIT_TICKS - 1));
  assign respawn    = reset || bus.start || hit_done;

  for (genvar i = 0; i < NUM_GHOSTS; i++) begin : g_ghost
    ghost_unit #(.GRID_W(GRID_W), .GRID_H(GRID_H), .IDX(i)) u_ghost (
      .clk     (clk),
      .respawn (respawn),
      .tick    (ghost_tick),
      .pac_x   (pac_x),
      .pac_y   (pac_y),
      .x       (ghost_x[i*XW +: XW]),
      .y       (ghost_y[i*YW +: YW])
    );
    assign ghost_hit[i] = (ghost_x[i*XW +: XW] == pac_x) && (ghost_y[i*YW +: YW] == pac_y);
  end

  always_ff @(posedge clk) begin
    if (reset || bus.start) begin
      state       <= reset ? IDLE : PLAY;
      pac_x       <= '0;
      pac_y       <= '0;
      fruit_alive <= '1;
      score       <= '0;
      steps       <= '0;
      lives       <= 3'(LIVES);
      hit_cnt     <= '0;
    end else begin
      case (state)
        PLAY: begin
          if (|fruit_hit) begin
            fruit_alive <= fruit_alive & ~fruit_hit;
            score <= (score > SCORE_W'(SCORE_MAX - FRUIT_POINTS)) ? SCORE_MAX
                                                                   : score + SCORE_W'(FRUIT_POINTS);
          end
          // A collision or win freezes the board on the cycle it is detected.
          if (go_win) begin
            state <= WIN;
          end else if (go_hit) begin
            lives   <= lives - 3'd1;
            hit_cnt <= '0;
            state   <= (lives == 3'd1) ? LOSE : HIT;
          end else if (move_ok) begin
            pac_x <= next_x;
            pac_y <= next_y;
            if (steps != SCORE_MAX) steps <= steps + 1'b1;
          end
        end
        HIT: begin
          if (hit_done) begin
            pac_x   <= '0;
            pac_y   <= '0;
            hit_cnt <= '0;
            state   <= PLAY;
          end else if (bus.g_tick) begin
            hit_cnt <= hit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pac_x       = pac_x;
  assign bus.pac_y       = pac_y;
  assign bus.ghost_x     = ghost_x;
  assign bus.ghost_y     = ghost_y;
  assign bus.fruit_alive = fruit_alive;
  assign bus.score       = score;
  assign bus.steps       = steps;
  assign bus.lives       = lives;
  assign bus.state       = state;

endmodule

// File: tb/tb_pacman_game_core.sv
// tb/tb_pacman_game_core.sv - directed and randomized checks of pacman_game_core against a rule-level model
module tb_pacman_game_core;

  localparam int W = 8, H = 8, NG = 2, NF = 3, NL = 3, FP = 100, HT = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_step   = 0;

  always #5 clk = ~clk;

  pacman_game_core_if #(.GRID_W(W), .GRID_H(H), .NUM_GHOSTS(NG), .NUM_FRUITS(NF)) bus ();
  pacman_game_core_if #(.GRID_W(4), .GRID_H(2), .NUM_GHOSTS(1), .NUM_FRUITS(2)) bus2 ();

  pacman_game_core #(
    .GRID_W(W), .GRID_H(H), .NUM_GHOSTS(NG), .NUM_FRUITS(NF),
    .LIVES(NL), .FRUIT_POINTS(FP), .HIT_TICKS(HT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pacman_game_core #(
    .GRID_W(4), .GRID_H(2), .NUM_GHOSTS(1), .NUM_FRUITS(2),
    .LIVES(3), .FRUIT_POINTS(100), .HIT_TICKS(4)
  ) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  // Reference model: plain integers following the game rules.
  int m_state, m_px, m_py, m_score, m_steps, m_lives, m_hcnt;
  int m_gx[NG], m_gy[NG], m_gd[NG];
  bit m_alive[NF];

  function automatic void spawn_actors();
    m_px = 0;
    m_py = 0;
    for (int i = 0; i < NG; i++) begin
      m_gx[i] = W - 1 - (i % W);
      m_gy[i] = H - 1 - i;
      m_gd[i] = 1;
    end
  endfunction

  function automatic void model_init(input int st);
    spawn_actors();
    for (int j = 0; j < NF; j++) m_alive[j] = 1'b1;
    m_score = 0;
    m_steps = 0;
    m_lives = NL;
    m_hcnt  = 0;
    m_state = st;
  endfunction

  function automatic void move_ghost(input int i, input int tx, input int ty);
`ifdef GHOST_CHASE_EN
    if (i % 2 == 1) begin
      if (tx != m_gx[i])      m_gx[i] += (tx > m_gx[i]) ? 1 : -1;
      else if (ty != m_gy[i]) m_gy[i] += (ty > m_gy[i]) ? 1 : -1;
      return;
    end
`endif
    if (m_gx[i] + m_gd[i] < 0 || m_gx[i] + m_gd[i] > W - 1) m_gd[i] = -m_gd[i];
    m_gx[i] += m_gd[i];
  endfunction

  function automatic void model_step(input bit s, input bit u, input bit d,
                                     input bit l, input bit r, input bit t);
    int fi, remaining, dx, dy, ox, oy;
    bit col;
    if (s) begin
      model_init(1);
      return;
    end
    if (m_state == 1) begin
      fi = -1;
      for (int j = 0; j < NF; j++)
        if (m_alive[j] && m_px == W - 1 && m_py == j) fi = j;
      col = 1'b0;
      for (int i = 0; i < NG; i++)
        if (m_gx[i] == m_px && m_gy[i] == m_py) col = 1'b1;
      if (fi >= 0) begin
        m_alive[fi] = 1'b0;
        m_score = (m_score + FP > 9999) ? 9999 : m_score + FP;
      end
      remaining = 0;
      for (int j = 0; j < NF; j++) remaining += int'(m_alive[j]);
      if (fi >= 0 && remaining == 0) begin
        m_state = 3;
      end else if (col) begin
        m_lives--;
        m_hcnt  = 0;
        m_state = (m_lives == 0) ? 4 : 2;
      end else begin
        ox = m_px;
        oy = m_py;
        dx = 0;
        dy = 0;
        if (u) dy = -1; else if (d) dy = 1; else if (l) dx = -1; else if (r) dx = 1;
        if ((dx != 0 || dy != 0) && m_px + dx >= 0 && m_px + dx < W &&
            m_py + dy >= 0 && m_py + dy < H) begin
          m_px += dx;
          m_py += dy;
          if (m_steps < 9999) m_steps++;
        end
        if (t) for (int i = 0; i < NG; i++) move_ghost(i, ox, oy);
      end
    end else if (m_state == 2 && t) begin
      m_hcnt++;
      if (m_hcnt == HT) begin
        spawn_actors();
        m_state = 1;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (step %0d): observed %0d, expected %0d", tag, n_step, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [NG*3-1:0] egx, egy;
    logic [NF-1:0]   ea;
    for (int i = 0; i < NG; i++) begin
      egx[i*3 +: 3] = 3'(m_gx[i]);
      egy[i*3 +: 3] = 3'(m_gy[i]);
    end
    for (int j = 0; j < NF; j++) ea[j] = m_alive[j];
    check("state", bus.state, m_state);
    check("pac_x", bus.pac_x, m_px);
    check("pac_y", bus.pac_y, m_py);
    check("ghost_x", bus.ghost_x, egx);
    check("ghost_y", bus.ghost_y, egy);
    check("fruit_alive", bus.fruit_alive, ea);
    check("score", bus.score, m_score);
    check("steps", bus.steps, m_steps);
    check("lives", bus.lives, m_lives);
  endtask

  task automatic step(input bit s, input bit u, input bit d, input bit l,
                      input bit r, input bit t, input bit rst = 1'b0);
    reset = rst;
    bus.start = s; bus.up = u; bus.down = d; bus.left = l; bus.right = r; bus.g_tick = t;
    if (rst) model_init(0);
    else     model_step(s, u, d, l, r, t);
    @(posedge clk);
    @(negedge clk);
    n_step++;
    reset = 1'b0;
    bus.start = 0; bus.up = 0; bus.down = 0; bus.left = 0; bus.right = 0; bus.g_tick = 0;
    compare_all();
  endtask

  task automatic step2(input bit s, input bit d, input bit r);
    bus2.start = s; bus2.down = d; bus2.right = r;
    model_step(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    n_step++;
    bus2.start = 0; bus2.down = 0; bus2.right = 0;
  endtask

  task automatic hit_ghost1();
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  int g0_seq[8] = '{6, 5, 4, 3, 2, 1, 0, 1};
  int g1_seq[8] = '{7, 6, 5, 4, 3, 2, 1, 0};

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.up = 0; bus.down = 0; bus.left = 0; bus.right = 0; bus.g_tick = 0;
    bus2.start = 0; bus2.up = 0; bus2.down = 0; bus2.left = 0; bus2.right = 0; bus2.g_tick = 0;

    step(0, 0, 0, 0, 0, 0, 1);
    check("rst_state", bus.state, 0);
    check("rst_lives", bus.lives, 3);
    check("rst_fruit", bus.fruit_alive, 3'b111);
    check("rst_ghost_x", bus.ghost_x, {3'd6, 3'd7});
    check("rst_ghost_y", bus.ghost_y, {3'd6, 3'd7});

    // Small grid: last fruit and ghost share (3,1).
    step2(1, 0, 0);
    for (int k = 0; k < 3; k++) step2(0, 0, 1);
    step2(0, 0, 0);
    check("small_score", bus2.score, 100);
    check("small_fruit", bus2.fruit_alive, 2'b10);
    step2(0, 1, 0);
    step2(0, 0, 0);
    check("small_win_state", bus2.state, 3);
    check("small_win_lives", bus2.lives, 3);
    check("small_win_fruit", bus2.fruit_alive, 2'b00);
    check("small_win_score", bus2.score, 200);
    step2(0, 0, 1);
    check("small_win_hold", bus2.pac_x, 3);
    compare_all();

    step(0, 1, 1, 1, 1, 1);
    check("idle_ignores", bus.state, 0);

    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 1, 0);
    check("r8_pac_x", bus.pac_x, 7);
    check("r8_pac_y", bus.pac_y, 0);
    check("r8_fruit", bus.fruit_alive, 3'b110);
    check("r8_score", bus.score, 100);
    check("r8_steps", bus.steps, 7);

    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    check("prio_pac_x", bus.pac_x, 3);
    check("prio_pac_y", bus.pac_y, 2);
    check("prio_steps", bus.steps, 7);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("edge_pac_y", bus.pac_y, 7);
    check("edge_steps", bus.steps, 12);

    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 0, 0, 1);
`ifdef GHOST_CHASE_EN
      check("chase_dist", 32'(bus.ghost_x[5:3]) + 32'(bus.ghost_y[5:3]), 11 - k);
`else
      check("patrol_g0", bus.ghost_x[2:0], g0_seq[k]);
      check("patrol_g1", bus.ghost_x[5:3], g1_seq[k]);
`endif
    end

    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("hit_state", bus.state, 2);
    check("hit_lives", bus.lives, 2);
    step(0, 0, 0, 0, 1, 0);
    check("hit_frozen", bus.pac_x, 6);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1);
    check("hit_wait", bus.state, 2);
    step(0, 0, 0, 0, 0, 1);
    check("respawn_state", bus.state, 1);
    check("respawn_pac", {bus.pac_x, bus.pac_y}, 0);
    check("respawn_fruit", bus.fruit_alive, 3'b110);
    check("respawn_score", bus.score, 100);

    hit_ghost1();
    check("hit2_lives", bus.lives, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 1);
    hit_ghost1();
    check("lose_state", bus.state, 4);
    check("lose_lives", bus.lives, 0);
    step(0, 1, 1, 1, 1, 1);
    check("lose_hold", bus.pac_x, 6);
    step(1, 0, 0, 0, 0, 0);
    check("restart_state", bus.state, 1);
    check("restart_lives", bus.lives, 3);
    check("restart_score", bus.score, 0);

    for (int k = 0; k < 800; k++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
